// File: rtl/sar_value_finder.sv
`default_nettype none
// ============================================================================
// Module      : sar_value_finder
// Description : Bit-serial successive-approximation engine. Drives the y side
//               of an external magnitude comparator, consumes its one-hot
//               xgty/xlty/xeqy verdicts and binary-searches the comparator's
//               hidden x operand, reporting it on result.
// Ports       : clk, rst        - rising-edge clock, synchronous active-high reset
//               start           - begin a search (honoured in IDLE/DONE/ERROR)
//               guess           - current probe value (comparator y operand)
//               guess_valid     - guess is stable and awaiting a verdict
//               cmp_valid       - verdict flags valid this cycle
//               xgty/xlty/xeqy  - x > guess / x < guess / x == guess
//               busy            - search in progress
//               done            - one-cycle pulse on successful completion
//               error           - level, inconsistent or malformed verdicts
//               result          - recovered x, valid from done until next start
//               probes          - verdicts accepted in current/last search
// Revision    : 1.0 - initial release
// ============================================================================
module sar_value_finder #(
    parameter int WIDTH = 3,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [WIDTH-1:0] guess,
    output logic             guess_valid,
    input  logic             cmp_valid,
    input  logic             xgty,
    input  logic             xlty,
    input  logic             xeqy,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [WIDTH-1:0] result,
    output logic [CNT_W-1:0] probes
);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_PROBE  = 3'd1;
    localparam logic [2:0] c_UPDATE = 3'd2;
    localparam logic [2:0] c_DONE   = 3'd3;
    localparam logic [2:0] c_ERROR  = 3'd4;

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [WIDTH:0]   c_LO_INIT     = '0;
    localparam logic [WIDTH:0]   c_HI_INIT     = {1'b0, {WIDTH{1'b1}}};
    // guess-1 taken at guess=0 leaves hi as all ones. A legal hi never
    // exceeds 2^WIDTH-1, so this pattern is read as "-1" (range empty).
    localparam logic [WIDTH:0]   c_HI_NEG      = {(WIDTH+1){1'b1}};
    localparam logic [WIDTH:0]   c_ONE_EXT     = {{WIDTH{1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] c_FIRST_GUESS = WIDTH'((2**WIDTH - 1) >> 1);
    localparam logic [CNT_W-1:0] c_PROBES_MAX  = '1;
    localparam logic [CNT_W-1:0] c_PROBES_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [2:0]       r_state;
    logic [WIDTH:0]   r_lo;
    logic [WIDTH:0]   r_hi;
    logic [WIDTH-1:0] r_guess;
    logic             r_guess_valid;
    logic             r_busy;
    logic             r_done;
    logic             r_error;
    logic [WIDTH-1:0] r_result;
    logic [CNT_W-1:0] r_probes;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic             w_onehot;
    logic             w_empty;
    logic [WIDTH:0]   w_guess_ext;
    logic [WIDTH:0]   w_guess_inc;
    logic [WIDTH:0]   w_guess_dec;
    logic [WIDTH-1:0] w_mid;
    logic [CNT_W-1:0] w_probes_next;

    // Exactly one verdict flag must be set for a verdict to be usable.
    assign w_onehot = ({xgty, xlty, xeqy} == 3'b100) ||
                      ({xgty, xlty, xeqy} == 3'b010) ||
                      ({xgty, xlty, xeqy} == 3'b001);

    // Search interval exhausted: either hi went "negative" or crossed lo.
    assign w_empty = (r_hi == c_HI_NEG) || (r_lo > r_hi);

    // Bounds are kept one bit wider than guess so guess+1 at the top of
    // the range does not wrap back to zero.
    assign w_guess_ext = {1'b0, r_guess};
    assign w_guess_inc = w_guess_ext + c_ONE_EXT;
    assign w_guess_dec = w_guess_ext - c_ONE_EXT;

    // Midpoint: (WIDTH+1)-bit sum, halved, truncated to WIDTH.
    assign w_mid = WIDTH'((r_lo + r_hi) >> 1);

    // Probe counter saturates rather than wrapping.
    assign w_probes_next = (r_probes == c_PROBES_MAX) ? r_probes
                                                      : (r_probes + c_PROBES_ONE);

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_IDLE;
            r_lo          <= c_LO_INIT;
            r_hi          <= c_HI_INIT;
            r_guess       <= '0;
            r_guess_valid <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_error       <= 1'b0;
            r_result      <= '0;
            r_probes      <= '0;
        end else begin
            // done is a single-cycle pulse on entry to DONE.
            r_done <= 1'b0;

            case (r_state)
                c_IDLE, c_DONE, c_ERROR: begin
                    if (start) begin
                        r_lo          <= c_LO_INIT;
                        r_hi          <= c_HI_INIT;
                        r_probes      <= '0;
                        r_error       <= 1'b0;
                        r_guess       <= c_FIRST_GUESS;
                        r_guess_valid <= 1'b1;
                        r_busy        <= 1'b1;
                        r_state       <= c_PROBE;
                    end
                end

                c_PROBE: begin
                    // guess is held; only a cycle with cmp_valid moves on.
                    if (cmp_valid) begin
                        r_probes      <= w_probes_next;
                        r_guess_valid <= 1'b0;
                        if (!w_onehot) begin
                            r_error <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= c_ERROR;
                        end else if (xeqy) begin
                            r_result <= r_guess;
                            r_done   <= 1'b1;
                            r_busy   <= 1'b0;
                            r_state  <= c_DONE;
                        end else if (xgty) begin
                            r_lo    <= w_guess_inc;
                            r_state <= c_UPDATE;
                        end else begin
                            r_hi    <= w_guess_dec;
                            r_state <= c_UPDATE;
                        end
                    end
                end

                c_UPDATE: begin
                    // Exactly one guess_valid-low cycle; cmp_valid is ignored.
                    if (w_empty) begin
                        r_error <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= c_ERROR;
                    end else begin
                        r_guess       <= w_mid;
                        r_guess_valid <= 1'b1;
                        r_state       <= c_PROBE;
                    end
                end

                default: begin
                    // Recover from an illegal encoding to a quiet idle.
                    r_guess_valid <= 1'b0;
                    r_busy        <= 1'b0;
                    r_state       <= c_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign guess       = r_guess;
    assign guess_valid = r_guess_valid;
    assign busy        = r_busy;
    assign done        = r_done;
    assign error       = r_error;
    assign result      = r_result;
    assign probes      = r_probes;

endmodule
`default_nettype wire

// File: tb/tb_sar_value_finder.sv
`default_nettype none
// ============================================================================
// Module      : tb_sar_value_finder
// Description : Self-checking bench for sar_value_finder. A plain-integer
//               binary-search model predicts the probe sequence; a per-cycle
//               compare process checks probe values, gap and status rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sar_value_finder;

    localparam int WIDTH = 3;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] guess;
    logic             guess_valid;
    logic             cmp_valid;
    logic             xgty;
    logic             xlty;
    logic             xeqy;
    logic             busy;
    logic             done;
    logic             error;
    logic [WIDTH-1:0] result;
    logic [CNT_W-1:0] probes;

    int n_checks = 0;
    int n_pass   = 0;

    int exp_q[$];
    bit exp_err;
    int idx      = 0;
    bit chk_on   = 1'b0;
    int done_cnt = 0;
    bit prev_gv  = 1'b0;

    sar_value_finder #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .guess       (guess),
        .guess_valid (guess_valid),
        .cmp_valid   (cmp_valid),
        .xgty        (xgty),
        .xlty        (xlty),
        .xeqy        (xeqy),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .result      (result),
        .probes      (probes)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference binary search over plain integers; x outside the range
    // models a comparator whose answers can never converge.
    function automatic void build_model(input int x);
        int lo;
        int hi;
        int g;
        lo = 0;
        hi = (1 << WIDTH) - 1;
        exp_q.delete();
        exp_err = 1'b0;
        forever begin
            if (lo > hi) begin
                exp_err = 1'b1;
                break;
            end
            g = (lo + hi) / 2;
            exp_q.push_back(g);
            if (x == g) break;
            if (x > g) lo = g + 1;
            else       hi = g - 1;
        end
    endfunction

    // Per-cycle compare process.
    always @(negedge clk) begin
        if (chk_on) begin
            if (guess_valid) begin
                if (idx < exp_q.size()) chk("probe_guess", int'(guess), exp_q[idx]);
                else                    chk("extra_probe", idx, exp_q.size());
                chk("busy_in_probe", int'(busy), 1);
            end
            if (busy && !guess_valid) chk("single_gap", int'(prev_gv), 1);
            if (done) begin
                done_cnt++;
                chk("done_not_busy", int'(busy), 0);
            end
            if (error) chk("error_not_busy", int'(busy), 0);
            prev_gv = guess_valid;
        end
    end

    // One complete search against a comparator holding x.
    //   delay  : cycles of guess_valid before cmp_valid is returned
    //   bad    : answer the first verdict with xgty and xlty both set
    //   inject : pulse a bogus xeqy verdict during every UPDATE cycle
    //   hold   : keep start high until this many verdicts were given
    task automatic run_search(input int x, input int delay, input bit bad,
                              input bit inject, input int hold,
                              input int exp_probes, input bit exp_error,
                              input int exp_res);
        int cyc;
        int g;
        bit fin;
        cyc = 0;
        fin = 1'b0;
        if (!bad) build_model(x);
        else      build_model(5);
        idx      = 0;
        done_cnt = 0;
        prev_gv  = 1'b0;
        chk_on   = 1'b1;

        start = 1'b1;
        tick();
        if (hold == 0) start = 1'b0;
        chk("start_guess", int'(guess), 3);
        chk("start_gv", int'(guess_valid), 1);
        chk("start_error_clr", int'(error), 0);
        chk("start_probes", int'(probes), 0);

        while (!fin && cyc < 300) begin
            if (idx >= hold) start = 1'b0;
            if (done || error) begin
                fin = 1'b1;
            end else if (guess_valid) begin
                repeat (delay) begin
                    tick();
                    cyc++;
                    chk("hold_gv", int'(guess_valid), 1);
                end
                g = int'(guess);
                cmp_valid = 1'b1;
                if (bad && idx == 0) begin
                    xgty = 1'b1; xlty = 1'b1; xeqy = 1'b0;
                end else begin
                    xgty = (x > g); xlty = (x < g); xeqy = (x == g);
                end
                tick();
                cyc++;
                cmp_valid = 1'b0;
                xgty = 1'b0; xlty = 1'b0; xeqy = 1'b0;
                idx++;
            end else begin
                if (inject && busy) begin
                    cmp_valid = 1'b1;
                    xeqy      = 1'b1;
                end
                tick();
                cyc++;
                cmp_valid = 1'b0;
                xeqy      = 1'b0;
            end
        end
        start = 1'b0;
        if (!fin) begin
            n_checks++;
            $display("FAIL timeout: x=%0d got no done/error in %0d cycles, required completion", x, cyc);
        end
        tick();
        tick();
        chk_on = 1'b0;
        chk("done_pulses", done_cnt, exp_error ? 0 : 1);
        chk("error_level", int'(error), int'(exp_error));
        chk("probes", int'(probes), exp_probes);
        chk("result", int'(result), exp_res);
        chk("busy_end", int'(busy), 0);
        chk("done_low_after", int'(done), 0);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        cmp_valid = 1'b0;
        xgty      = 1'b0;
        xlty      = 1'b0;
        xeqy      = 1'b0;

        // Hand-computed pins on the model itself.
        build_model(5);
        chk("model_x5_len", exp_q.size(), 2);
        chk("model_x5_p1", exp_q[1], 5);
        build_model(7);
        chk("model_x7_len", exp_q.size(), 4);
        chk("model_x7_p2", exp_q[2], 6);
        build_model(0);
        chk("model_x0_p1", exp_q[1], 1);
        build_model(-1);
        chk("model_under_len", exp_q.size(), 3);
        chk("model_under_err", int'(exp_err), 1);

        // Reset state.
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_guess", int'(guess), 0);
        chk("rst_gv", int'(guess_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_error", int'(error), 0);
        chk("rst_result", int'(result), 0);
        chk("rst_probes", int'(probes), 0);
        tick();

        //          x  dly bad inj hold probes err result
        run_search( 0, 0, 1'b0, 1'b0, 0, 3, 1'b0, 0);
        run_search( 5, 0, 1'b0, 1'b0, 0, 2, 1'b0, 5);
        run_search( 7, 0, 1'b0, 1'b0, 0, 4, 1'b0, 7);
        // Comparator that always says x<guess: range underflows, result kept.
        run_search(-1, 0, 1'b0, 1'b0, 0, 3, 1'b1, 7);
        // Two flags on the first verdict.
        run_search( 5, 0, 1'b1, 1'b0, 0, 1, 1'b1, 7);
        // Slow responder with bogus verdicts during UPDATE.
        run_search( 2, 5, 1'b0, 1'b1, 0, 3, 1'b0, 2);
        // start held high through the first two verdicts.
        run_search( 6, 0, 1'b0, 1'b0, 2, 3, 1'b0, 6);

        // Reset in the middle of a probe.
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("pre_rst_gv", int'(guess_valid), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_guess", int'(guess), 0);
        chk("abort_gv", int'(guess_valid), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_error", int'(error), 0);
        chk("abort_result", int'(result), 0);
        chk("abort_probes", int'(probes), 0);
        tick();
        tick();
        chk("idle_gv", int'(guess_valid), 0);
        chk("idle_busy", int'(busy), 0);

        run_search( 4, 0, 1'b0, 1'b0, 0, 3, 1'b0, 4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
